accum_datapath: RTL and testbench
=================================

// Module: accum_datapath
// PURPOSE
//  Execution datapath slaved to the instruction controller FSM: holds PC, IR, a 16x8 register file,
//  the accumulator, the ALU and the Z/C flags. Consumes LoadIR/IncPC/selPC/LoadPC/LoadReg/LoadAcc/
//  SelAcc/SelALU and returns the instruction byte I and flags zout/cout to the controller.
//  Fetches from external program memory through pmem_addr/pmem_data.
// PARAMETERS
//  DW   8  data/accumulator/register width
//  PCW  8  program counter width (pmem depth 2**PCW)
// PORTS
//  clk        in   1    system clock, all state on posedge
//  CLB        in   1    synchronous, active-high reset
//  LoadIR     in   1    IR <= pmem_data
//  IncPC      in   1    PC <= PC+1
//  selPC      in   1    jump target select: 0 absolute, 1 PC-relative
//  LoadPC     in   1    PC <= jump target
//  LoadReg    in   1    R[IR[7:4]] <= ACC
//  LoadAcc    in   1    ACC <= mux(SelAcc)
//  SelAcc     in   2    00 R[IR[7:4]], 01 ALU result, 10 zero-ext IR[7:4], 11 hold ACC
//  SelALU     in   4    ALU op, see BEHAVIOUR
//  pmem_data  in   8    instruction byte at pmem_addr (combinational memory)
//  pmem_addr  out  PCW  = PC
//  I          out  8    = IR ({operand[7:4], opcode[3:0]})
//  zout       out  1    zero flag (registered)
//  cout       out  1    carry/borrow flag (registered)
//  acc_out    out  DW   = ACC (observation)
// BEHAVIOUR
//  - Reset (CLB=1 at posedge): PC=0, IR=0x00 (NOP), ACC=0, all 16 R=0, zout=0, cout=0. CLB overrides every
//    control input in the same cycle; mid-instruction reset discards all pending loads.
//  - All updates registered; control sampled at posedge takes effect that edge, visible next cycle (1-cycle latency).
//  - PC priority: CLB > LoadPC > IncPC. LoadPC with selPC=0: PC <= zero-ext IR[7:4];
//    selPC=1: PC <= PC + sign-ext IR[7:4] (mod 2**PCW). IncPC wraps 2**PCW-1 -> 0. LoadPC+IncPC same edge: jump wins.
//  - IR: LoadIR captures pmem_data; otherwise holds. I is IR directly (no bypass of pmem_data).
//  - ALU, A=ACC, B=R[IR[7:4]], 9-bit internal result {c,r}:
//    0000 r=B c=0 | 0001 ADD A+B, c=carry | 0010 SUB A-B, c=borrow (A<B) | 0011 NOR ~(A|B) c=0
//    0100 SHL r=A<<1, c=A[7] | 0101 SHR r=A>>1, c=A[0] | others r=A c=0.
//  - Flags update only when LoadAcc=1 and SelAcc=01: zout=(r==0), cout=c. All other cycles hold flags,
//    including LoadAcc with SelAcc!=01 and LoadReg.
//  - Register file: one write port (LoadReg), one async read port addressed by IR[7:4]. Register 0 is ordinary.
//  - Simultaneous LoadReg+LoadAcc: register receives pre-edge ACC; ACC receives mux value computed from
//    pre-edge register contents (no write-through).
//  - LoadIR in same edge as LoadReg/LoadAcc: those use pre-edge IR[7:4] for addressing/immediate.
//  - SelAcc=11 with LoadAcc=1: ACC unchanged, flags unchanged.
// TESTING
//  1 Reset: drive junk controls with CLB=1 -> next cycle PC=0, I=0x00, acc_out=0, zout=cout=0, R all 0.
//  2 Fetch/wrap: pmem[0x00]=0x54, LoadIR+IncPC -> I=0x54, PC=1; preload PC=0xFF, IncPC -> PC=0x00.
//  3 ADD carry: ACC=0xF0, R5=0x20, IR=0x51, LoadAcc SelAcc=01 SelALU=0001 -> ACC=0x10, cout=1, zout=0.
//  4 SUB zero/borrow: ACC=0x33,R3=0x33,SUB -> ACC=0, zout=1,cout=0; then R3=0x40 -> ACC=0xC0? no: ACC=0x00-0x40=0xC0, cout=1, zout=0.
//  5 Jumps: PC=0x10, IR=0xE6, LoadPC selPC=0 -> PC=0x0E; PC=0x10, selPC=1 -> PC=0x0E (0x10-2); LoadPC+IncPC -> jump wins.
//  6 Store/immediate collision: ACC=0x7A, IR=0x94, LoadReg+LoadAcc SelAcc=10 same edge -> R9=0x7A, ACC=0x09, flags unchanged.

Source files
------------

// File: rtl/accum_datapath.sv
// Execution datapath for the accumulator machine: PC, IR, 16-entry register file,
// accumulator, ALU and Z/C flags, all driven by the instruction controller's strobes.
module accum_datapath #(
  parameter int DW  = 8,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           CLB,
  input  logic           LoadIR,
  input  logic           IncPC,
  input  logic           selPC,
  input  logic           LoadPC,
  input  logic           LoadReg,
  input  logic           LoadAcc,
  input  logic [1:0]     SelAcc,
  input  logic [3:0]     SelALU,
  input  logic [7:0]     pmem_data,
  output logic [PCW-1:0] pmem_addr,
  output logic [7:0]     I,
  output logic           zout,
  output logic           cout,
  output logic [DW-1:0]  acc_out
);

  logic [PCW-1:0] pc_q, pc_d;
  logic [7:0]     ir_q, ir_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic           z_q, z_d;
  logic           c_q, c_d;
  logic [DW-1:0]  rf_q [16];

  logic [3:0]     op_field_s;
  logic [DW-1:0]  reg_rd_s;
  logic [DW:0]    alu_s;

  assign op_field_s = ir_q[7:4];
  assign reg_rd_s   = rf_q[op_field_s];

  // ALU: bit DW of the 9-bit result is the carry, or the borrow for SUB
  always_comb begin
    alu_s = {1'b0, acc_q};
    case (SelALU)
      4'h0:    alu_s = {1'b0, reg_rd_s};
      4'h1:    alu_s = {1'b0, acc_q} + {1'b0, reg_rd_s};
      4'h2:    alu_s = {1'b0, acc_q} - {1'b0, reg_rd_s};
      4'h3:    alu_s = {1'b0, ~(acc_q | reg_rd_s)};
      4'h4:    alu_s = {acc_q[DW-1], acc_q[DW-2:0], 1'b0};
      4'h5:    alu_s = {acc_q[0], 1'b0, acc_q[DW-1:1]};
      default: alu_s = {1'b0, acc_q};
    endcase
  end

  // Next-state for PC, IR, ACC and flags; a jump beats an increment
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    acc_d = acc_q;
    z_d   = z_q;
    c_d   = c_q;

    if (LoadPC) begin
      if (selPC) begin
        pc_d = pc_q + {{(PCW-4){op_field_s[3]}}, op_field_s};
      end else begin
        pc_d = {{(PCW-4){1'b0}}, op_field_s};
      end
    end else if (IncPC) begin
      pc_d = pc_q + {{(PCW-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end

    if (LoadIR) begin
      ir_d = pmem_data;
    end else begin
      ir_d = ir_q;
    end

    if (LoadAcc) begin
      case (SelAcc)
        2'b00: acc_d = reg_rd_s;
        2'b01: begin
          acc_d = alu_s[DW-1:0];
          z_d   = (alu_s[DW-1:0] == {DW{1'b0}});
          c_d   = alu_s[DW];
        end
        2'b10: acc_d = {{(DW-4){1'b0}}, op_field_s};
        2'b11: acc_d = acc_q;
        default: acc_d = acc_q;
      endcase
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers; CLB discards every pending load in the same edge
  always_ff @(posedge clk) begin
    if (CLB) begin
      pc_q  <= {PCW{1'b0}};
      ir_q  <= 8'h00;
      acc_q <= {DW{1'b0}};
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      z_q   <= z_d;
      c_q   <= c_d;
    end
  end

  // Register file write port; the stored value is the pre-edge accumulator
  always_ff @(posedge clk) begin
    if (CLB) begin
      for (int k = 0; k < 16; k++) begin
        rf_q[k] <= {DW{1'b0}};
      end
    end else if (LoadReg) begin
      rf_q[op_field_s] <= acc_q;
    end else begin
      rf_q[op_field_s] <= rf_q[op_field_s];
    end
  end

  assign pmem_addr = pc_q;
  assign I         = ir_q;
  assign zout      = z_q;
  assign cout      = c_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_accum_datapath.sv
// Directed and randomized checks of accum_datapath against an arithmetic reference model.
module tb_accum_datapath;

  logic       clk = 1'b0;
  logic       CLB, LoadIR, IncPC, selPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic [7:0] pmem_data;
  logic [7:0] pmem_addr;
  logic [7:0] I;
  logic       zout, cout;
  logic [7:0] acc_out;

  logic [7:0] pmem [256];

  int m_pc, m_ir, m_acc, m_z, m_c;
  int m_rf [16];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign pmem_data = pmem[pmem_addr];

  accum_datapath #(.DW(8), .PCW(8)) dut (
    .clk(clk), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .selPC(selPC),
    .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc),
    .SelALU(SelALU), .pmem_data(pmem_data), .pmem_addr(pmem_addr), .I(I),
    .zout(zout), .cout(cout), .acc_out(acc_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: next state from pre-edge state using plain integer arithmetic
  task automatic model(input bit clb, ldir, inc, selpc, ldpc, ldreg, ldacc,
                       input bit [1:0] sa, input bit [3:0] op);
    int nib, a, b, r, c, npc, off;
    if (clb) begin
      m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
      for (int k = 0; k < 16; k++) m_rf[k] = 0;
      return;
    end
    nib = m_ir / 16;
    a = m_acc;
    b = m_rf[nib];
    c = 0;
    case (op)
      4'h0: r = b;
      4'h1: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      4'h2: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      4'h3: r = 255 - (a | b);
      4'h4: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      4'h5: begin r = a / 2; c = a % 2; end
      default: r = a;
    endcase
    npc = m_pc;
    if (ldpc) begin
      off = (nib >= 8) ? nib - 16 : nib;
      npc = selpc ? (m_pc + off + 256) % 256 : nib;
    end else if (inc) begin
      npc = (m_pc + 1) % 256;
    end
    if (ldir) m_ir = pmem[m_pc];
    if (ldreg) m_rf[nib] = a;
    if (ldacc) begin
      case (sa)
        2'd0: m_acc = b;
        2'd1: begin m_acc = r; m_z = (r == 0) ? 1 : 0; m_c = c; end
        2'd2: m_acc = nib;
        default: ;
      endcase
    end
    m_pc = npc;
  endtask

  task automatic step(input bit clb, ldir, inc, selpc, ldpc, ldreg, ldacc,
                      input bit [1:0] sa, input bit [3:0] op);
    CLB = clb; LoadIR = ldir; IncPC = inc; selPC = selpc; LoadPC = ldpc;
    LoadReg = ldreg; LoadAcc = ldacc; SelAcc = sa; SelALU = op;
    @(posedge clk);
    model(clb, ldir, inc, selpc, ldpc, ldreg, ldacc, sa, op);
    #1;
    chk("pc",   {8'h00, pmem_addr}, 16'(m_pc));
    chk("ir",   {8'h00, I},         16'(m_ir));
    chk("acc",  {8'h00, acc_out},   16'(m_acc));
    chk("zout", {15'h0, zout},      16'(m_z));
    chk("cout", {15'h0, cout},      16'(m_c));
  endtask

  task automatic set_ir(input logic [7:0] v);
    pmem[m_pc[7:0]] = v;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
  endtask

  // Builds an arbitrary ACC byte from nibble immediates, shifts and an ADD via R14
  task automatic set_acc(input logic [7:0] v);
    set_ir({v[7:4], 4'h0});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'h0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'h4);
    set_ir(8'hE0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0);
    set_ir({v[3:0], 4'h0});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'h0);
    set_ir(8'hE1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'h1);
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [7:0] v);
    set_acc(v);
    set_ir({idx, 4'h0});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0);
  endtask

  initial begin
    logic [15:0] rv;
    int zf, cf;
    for (int k = 0; k < 256; k++) pmem[k] = 8'h00;
    CLB = 1'b1; LoadIR = 1'b0; IncPC = 1'b0; selPC = 1'b0; LoadPC = 1'b0;
    LoadReg = 1'b0; LoadAcc = 1'b0; SelAcc = 2'b00; SelALU = 4'h0;
    m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
    for (int k = 0; k < 16; k++) m_rf[k] = 0;
    #2;

    // Reset with junk controls asserted
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 4'h1);
    chk("rst_pc",  {8'h00, pmem_addr}, 16'h0000);
    chk("rst_ir",  {8'h00, I},         16'h0000);
    chk("rst_acc", {8'h00, acc_out},   16'h0000);
    chk("rst_zc",  {14'h0, zout, cout}, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      pmem[k] = {4'(k), 4'h0};
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'h0);
      chk("rst_rf", {8'h00, acc_out}, 16'h0000);
    end

    // Fetch and PC wrap
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    pmem[0] = 8'h54;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    chk("fetch_ir", {8'h00, I},         16'h0054);
    chk("fetch_pc", {8'h00, pmem_addr}, 16'h0001);
    for (int k = 0; k < 254; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    chk("pc_ff", {8'h00, pmem_addr}, 16'h00FF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    chk("pc_wrap", {8'h00, pmem_addr}, 16'h0000);

    // ADD with carry out
    set_reg(4'd5, 8'h20);
    set_acc(8'hF0);
    set_ir(8'h51);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'h1);
    chk("add_acc", {8'h00, acc_out},    16'h0010);
    chk("add_zc",  {14'h0, zout, cout}, 16'h0001);

    // SUB to zero, then SUB with borrow
    set_reg(4'd3, 8'h33);
    set_acc(8'h33);
    set_ir(8'h32);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'h2);
    chk("sub0_acc", {8'h00, acc_out},    16'h0000);
    chk("sub0_zc",  {14'h0, zout, cout}, 16'h0002);
    set_reg(4'd3, 8'h40);
    set_acc(8'h00);
    set_ir(8'h32);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'h2);
    chk("subb_acc", {8'h00, acc_out},    16'h00C0);
    chk("subb_zc",  {14'h0, zout, cout}, 16'h0001);

    // Absolute, relative and jump-beats-increment
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    set_ir(8'hE6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    chk("jabs", {8'h00, pmem_addr}, 16'h000E);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    chk("pc_10", {8'h00, pmem_addr}, 16'h0010);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    chk("jrel", {8'h00, pmem_addr}, 16'h000E);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    chk("jwin", {8'h00, pmem_addr}, 16'h000C);

    // Store and immediate load in the same edge
    set_acc(8'h7A);
    set_ir(8'h94);
    zf = m_z; cf = m_c;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 4'h1);
    chk("coll_acc", {8'h00, acc_out}, 16'h0009);
    chk("coll_flg", {14'h0, zout, cout}, 16'(zf * 2 + cf));
    set_ir(8'h90);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'h0);
    chk("coll_r9", {8'h00, acc_out}, 16'h007A);

    // Random control traffic over random program memory
    for (int k = 0; k < 256; k++) pmem[k] = 8'($urandom());
    for (int n = 0; n < 3000; n++) begin
      rv = 16'($urandom());
      step(($urandom_range(0, 40) == 0), rv[0], rv[1], rv[2], ($urandom_range(0, 3) == 0),
           rv[3], rv[4], rv[6:5], {1'b0, rv[9:7]} ^ {rv[10], 3'b000});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
